seq_divider: RTL

Sequential unsigned integer divider, the inverse of the Booth multiplier: it divides a WIDTH-bit dividend by a WIDTH-bit divisor using restoring division, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath. It uses a start/busy/done handshake and holds its results until the next accepted start.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 53 +++++
 rtl/gate_lib.sv | 32 +++
 rtl/seq_divider.sv | 116 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
// Pure declarations, no logic.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEFAULT = 8;

   // Iteration counter width; count runs WIDTH-1 down to 0.
   function automatic int div_cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q}, trial-subtract divisor, restore or keep.
// Combinational, zero latency, no flow control.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH:0]  rq,
   input  logic [WIDTH-1:0]  divisor,
   output logic [2*WIDTH:0]  rq_next
);
   localparam int RW = WIDTH + 2;

   logic [RW-1:0]  a;
   logic [RW-1:0]  b;
   logic [RW-1:0]  bn;
   logic [RW-1:0]  p;
   logic [RW-1:0]  g;
   logic [RW-1:0]  pc;
   logic [RW:0]    c;
   logic [WIDTH:0] t;
   logic [WIDTH:0] take;
   logic [WIDTH:0] keep;
   logic [WIDTH:0] r_new;
   logic           ge;
   logic           ge_n;

   // Subtract on W+2 bits so the bit shifted out of R takes part in the compare.
   assign a    = {rq[2*WIDTH:WIDTH], rq[WIDTH-1]};
   assign b    = {2'b00, divisor};
   assign c[0] = 1'b1;
   assign ge   = c[RW];

   for (genvar i = 0; i < RW; i++) begin : g_sub
      invert u_inv (.a(b[i]), .y(bn[i]));
      xor2   u_p   (.a(a[i]), .b(bn[i]), .y(p[i]));
      and2   u_g   (.a(a[i]), .b(bn[i]), .y(g[i]));
      and2   u_pc  (.a(p[i]), .b(c[i]),  .y(pc[i]));
      or2    u_c   (.a(g[i]), .b(pc[i]), .y(c[i+1]));
      if (i <= WIDTH) begin : g_sum
         xor2 u_s (.a(p[i]), .b(c[i]), .y(t[i]));
      end
   end

   invert u_ge_n (.a(ge), .y(ge_n));

   for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
      and2 u_take (.a(t[i]), .b(ge),   .y(take[i]));
      and2 u_keep (.a(a[i]), .b(ge_n), .y(keep[i]));
      or2  u_sel  (.a(take[i]), .b(keep[i]), .y(r_new[i]));
   end

   assign rq_next = {r_new, rq[WIDTH-2:0], ge};

endmodule

// File: rtl/gate_lib.sv
// Shared gate-library primitives used by the arithmetic datapath.
// Combinational, zero latency, no flow control.
module xor2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

module and2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module invert (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; SEQ_DIVIDER_SIGNED_EN selects two's complement.
// Latency WIDTH+1 cycles (1 for divide-by-zero); start ignored while busy, results held until next start.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = div_cnt_width(WIDTH);

   div_state_e       state;
   logic [2*WIDTH:0] rq;
   logic [2*WIDTH:0] rq_next;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic q_neg;
   logic r_neg;

   assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
   // Most-negative / -1 needs no special case: magnitude 2^(W-1) comes back unchanged.
   assign q_fix = q_neg ? -rq_next[WIDTH-1:0]       : rq_next[WIDTH-1:0];
   assign r_fix = r_neg ? -rq_next[2*WIDTH-1:WIDTH] : rq_next[2*WIDTH-1:WIDTH];
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
   assign q_fix        = rq_next[WIDTH-1:0];
   assign r_fix        = rq_next[2*WIDTH-1:WIDTH];
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rq      (rq),
      .divisor (dvs),
      .rq_next (rq_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rq          <= '0;
         dvs         <= '0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     rq    <= {{(WIDTH+1){1'b0}}, dividend_mag};
                     dvs   <= divisor_mag;
                     count <= CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                     q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     r_neg <= dividend[WIDTH-1];
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rq <= rq_next;
               if (count == '0) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= q_fix;
                  remainder   <= r_fix;
                  div_by_zero <= 1'b0;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
